// File: rtl/fmdll_frac_div_if.sv
// Ratio-control and enable bundle for fmdll_frac_div.
// master drives M/N/cfg_load; slave returns div_en/CLK_div/frame_start/status.
interface fmdll_frac_div_if #(
  parameter int M_W = 2,
  parameter int N_W = 4
);
  logic [M_W-1:0] M;
  logic [N_W-1:0] N;
  logic           cfg_load;
  logic           div_en;
  logic           CLK_div;
  logic           frame_start;
  logic           cfg_busy;
  logic           cfg_err;

  modport master (
    output M, N, cfg_load,
    input  div_en, CLK_div, frame_start,
    input  cfg_busy, cfg_err
  );

  modport slave (
    input  M, N, cfg_load,
    output div_en, CLK_div, frame_start,
    output cfg_busy, cfg_err
  );
endinterface

// File: rtl/fmdll_frac_div.sv
// Fractional clock-enable divider: M enables per N-cycle frame on CLK_exit.
// Ports: CLK_exit, rst_n (async low), bus (slave: M/N/cfg_load in, pulses+status out).
module fmdll_frac_div #(
  parameter int M_W   = 2,
  parameter int N_W   = 4,
  parameter int M_RST = 1,
  parameter int N_RST = 2
) (
  input  logic              CLK_exit,
  input  logic              rst_n,
  fmdll_frac_div_if.slave   bus
);
  localparam int AW = N_W + 1;

  logic [M_W-1:0] m_q, m_d, mp_q, mp_d;
  logic [N_W-1:0] n_q, n_d, np_q, np_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]  acc_q, acc_d, sum;
  logic           pend_q, pend_d;
  logic           en_q, en_d;
  logic           clk_q, clk_d;
  logic           fs_q, fs_d;
  logic           err_q, err_d;
  logic           wrap, req_ok;

  always_comb begin
    sum    = acc_q + AW'(m_q);
    wrap   = (cnt_q == n_q - 1'b1);
    req_ok = (bus.M != '0) && (bus.N != '0)
          && (AW'(bus.M) <= AW'(bus.N));
    m_d    = m_q;
    n_d    = n_q;
    mp_d   = mp_q;
    np_d   = np_q;
    pend_d = pend_q;
    err_d  = err_q;
    clk_d  = clk_q;
    fs_d   = wrap;
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    unique case (1'b1)
      (sum >= AW'(n_q)): begin
        acc_d = sum - AW'(n_q);
        en_d  = 1'b1;
        clk_d = ~clk_q;
      end
      default: begin
        acc_d = sum;
        en_d  = 1'b0;
      end
    endcase
    // Only a request pending before this wrap is applied here.
    if (wrap && pend_q) begin
      m_d    = mp_q;
      n_d    = np_q;
      acc_d  = '0;
      pend_d = 1'b0;
    end
    // A load on the wrap edge re-arms pend for the next wrap.
    if (bus.cfg_load) begin
      if (req_ok) begin
        mp_d   = bus.M;
        np_d   = bus.N;
        pend_d = 1'b1;
        err_d  = 1'b0;
      end else begin
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_exit or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= M_W'(M_RST);
      n_q    <= N_W'(N_RST);
      mp_q   <= '0;
      np_q   <= '0;
      pend_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      clk_q  <= 1'b0;
      fs_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      m_q    <= m_d;
      n_q    <= n_d;
      mp_q   <= mp_d;
      np_q   <= np_d;
      pend_q <= pend_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      clk_q  <= clk_d;
      fs_q   <= fs_d;
      err_q  <= err_d;
    end
  end

  assign bus.div_en      = en_q;
  assign bus.CLK_div     = clk_q;
  assign bus.frame_start = fs_q;
  assign bus.cfg_busy    = pend_q;
  assign bus.cfg_err     = err_q;
endmodule
